// File: rtl/wb_regfile.sv
// Write-back stage: captures the EX register write, commits it to a 32 x 32 integer
// register file one cycle later, and serves two forwarding read ports (x0 reads zero).
// Optional macro WB_EX_BYPASS_EN also forwards the EX write to the read ports in its own cycle.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] rd_wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic              commit_valid_o,
    output logic [ADDR_W-1:0] commit_addr_o,
    output logic [DATA_W-1:0] commit_data_o,
    output logic [31:0]       commit_cnt_o
);

    logic              wb_valid_reg;
    logic [ADDR_W-1:0] wb_addr_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic              commit_valid_reg;
    logic [ADDR_W-1:0] commit_addr_reg;
    logic [DATA_W-1:0] commit_data_reg;
    logic [31:0]       commit_cnt_reg;
    logic [DATA_W-1:0] rf_reg [NUM_REGS];

    // Writes to x0 are dropped at capture so they never commit or count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= '0;
            wb_data_reg  <= '0;
        end else begin
            wb_valid_reg <= reg_we_i && (wr_addr_i != '0);
            wb_addr_reg  <= wr_addr_i;
            wb_data_reg  <= rd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            commit_valid_reg <= 1'b0;
            commit_addr_reg  <= '0;
            commit_data_reg  <= '0;
            commit_cnt_reg   <= '0;
        end else begin
            commit_valid_reg <= wb_valid_reg;
            if (wb_valid_reg) begin
                commit_addr_reg <= wb_addr_reg;
                commit_data_reg <= wb_data_reg;
                commit_cnt_reg  <= commit_cnt_reg + 32'd1;
            end
        end
    end

    // The whole array clears on reset, so it is kept in flops rather than block RAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (wb_valid_reg) begin
            rf_reg[wb_addr_reg] <= wb_data_reg;
        end
    end

    // Youngest source wins: EX (optional), then the pending wb entry, then the array.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = rf_reg[addr];
        if (rst_i || addr == '0) begin
            val = '0;
        end
`ifdef WB_EX_BYPASS_EN
        else if (reg_we_i && wr_addr_i == addr) begin
            val = rd_wdata_i;
        end
`endif
        else if (wb_valid_reg && wb_addr_reg == addr) begin
            val = wb_data_reg;
        end
        return val;
    endfunction

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = raddr_a_i;
    assign rd_addr[1] = raddr_b_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign rd_data[gi] = read_port(rd_addr[gi]);
        end
    endgenerate

    assign rdata_a_o      = rd_data[0];
    assign rdata_b_o      = rd_data[1];
    assign commit_valid_o = commit_valid_reg;
    assign commit_addr_o  = commit_addr_reg;
    assign commit_data_o  = commit_data_reg;
    assign commit_cnt_o   = commit_cnt_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: an architectural model (latest accepted write per register, commits
// two edges after issue) is compared every cycle, plus hand-computed literal expectations.
module tb_wb_regfile;

    localparam int S_RA  = 0;
    localparam int S_RB  = 1;
    localparam int S_CV  = 2;
    localparam int S_CA  = 3;
    localparam int S_CD  = 4;
    localparam int S_CNT = 5;

`ifdef WB_EX_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk_i      = 1'b0;
    logic        rst_i      = 1'b1;
    logic        reg_we_i   = 1'b0;
    logic [4:0]  wr_addr_i  = '0;
    logic [31:0] rd_wdata_i = '0;
    logic [4:0]  raddr_a_i  = '0;
    logic [4:0]  raddr_b_i  = '0;
    logic [31:0] rdata_a_o;
    logic [31:0] rdata_b_o;
    logic        commit_valid_o;
    logic [4:0]  commit_addr_o;
    logic [31:0] commit_data_o;
    logic [31:0] commit_cnt_o;

    always #5 clk_i = ~clk_i;

    wb_regfile dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .reg_we_i       (reg_we_i),
        .wr_addr_i      (wr_addr_i),
        .rd_wdata_i     (rd_wdata_i),
        .raddr_a_i      (raddr_a_i),
        .raddr_b_i      (raddr_b_i),
        .rdata_a_o      (rdata_a_o),
        .rdata_b_o      (rdata_b_o),
        .commit_valid_o (commit_valid_o),
        .commit_addr_o  (commit_addr_o),
        .commit_data_o  (commit_data_o),
        .commit_cnt_o   (commit_cnt_o)
    );

    // Architectural model: arch holds the latest accepted write per register; hist[1] is the
    // write issued two edges ago, which is the one committing in the current cycle.
    typedef struct packed {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         hist [$];
    logic [31:0] arch [32];
    logic [31:0] ncommit = '0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) arch[i] <= '0;
            hist.delete();
            ncommit <= '0;
        end else begin
            if (reg_we_i && wr_addr_i != 5'd0) arch[wr_addr_i] <= rd_wdata_i;
            hist.push_front(wr_t'{reg_we_i && wr_addr_i != 5'd0, wr_addr_i, rd_wdata_i});
            if (hist.size() > 2) void'(hist.pop_back());
            if (hist.size() == 2 && hist[1].v) ncommit <= ncommit + 32'd1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (rst_i || a == 5'd0) return 32'd0;
        if (BYPASS && reg_we_i && wr_addr_i == a) return rd_wdata_i;
        return arch[a];
    endfunction

    // Literal expectations posted by the stimulus for the current cycle.
    logic        lit_en  [6];
    logic [31:0] lit_exp [6];
    logic [31:0] cnt_base = '0;

    function automatic string sig_name(input int s);
        case (s)
            S_RA:    return "rdata_a";
            S_RB:    return "rdata_b";
            S_CV:    return "commit_valid";
            S_CA:    return "commit_addr";
            S_CD:    return "commit_data";
            default: return "commit_cnt";
        endcase
    endfunction

    function automatic logic [31:0] dut_sig(input int s);
        case (s)
            S_RA:    return rdata_a_o;
            S_RB:    return rdata_b_o;
            S_CV:    return {31'd0, commit_valid_o};
            S_CA:    return {27'd0, commit_addr_o};
            S_CD:    return commit_data_o;
            default: return commit_cnt_o;
        endcase
    endfunction

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL cyc=%0d %s: got %h expected %h", cyc, name, act, exp);
        end
    endtask

    logic exp_cv;

    always @(negedge clk_i) begin
        #4;
        cyc++;
        check("rdata_a", rdata_a_o, exp_rd(raddr_a_i));
        check("rdata_b", rdata_b_o, exp_rd(raddr_b_i));
        exp_cv = !rst_i && hist.size() == 2 && hist[1].v;
        check("commit_valid", {31'd0, commit_valid_o}, {31'd0, exp_cv});
        if (exp_cv) begin
            check("commit_addr", {27'd0, commit_addr_o}, {27'd0, hist[1].a});
            check("commit_data", commit_data_o, hist[1].d);
        end
        check("commit_cnt", commit_cnt_o, cnt_base + ncommit);
        for (int i = 0; i < 6; i++) begin
            if (lit_en[i]) check({"lit_", sig_name(i)}, dut_sig(i), lit_exp[i]);
        end
        $display("cyc=%0d rst=%0b we=%0b wa=%0d wd=%h ra=%0d:%h rb=%0d:%h cv=%0b ca=%0d cd=%h cnt=%h",
                 cyc, rst_i, reg_we_i, wr_addr_i, rd_wdata_i, raddr_a_i, rdata_a_o,
                 raddr_b_i, rdata_b_o, commit_valid_o, commit_addr_o, commit_data_o, commit_cnt_o);
    end

    task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk_i);
        reg_we_i   = we;
        wr_addr_i  = a;
        rd_wdata_i = d;
        raddr_a_i  = ra;
        raddr_b_i  = rb;
        for (int i = 0; i < 6; i++) lit_en[i] = 1'b0;
    endtask

    task automatic lit(input int s, input logic [31:0] v);
        lit_en[s]  = 1'b1;
        lit_exp[s] = v;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            lit_en[i]  = 1'b0;
            lit_exp[i] = '0;
        end

        // Reset held, then released; every address reads zero on both ports.
        step(1'b1, 5'd9, 32'h5A5A5A5A, 5'd9, 5'd9);
        lit(S_RA, 32'd0); lit(S_CNT, 32'd0);
        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd31);
        rst_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            lit(S_RA, 32'd0); lit(S_RB, 32'd0); lit(S_CV, 32'd0); lit(S_CNT, 32'd0);
        end

        // Single write x5 = DEADBEEF, read across N..N+3.
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        lit(S_RA, BYPASS ? 32'hDEADBEEF : 32'd0); lit(S_CV, 32'd0);
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        lit(S_RA, 32'hDEADBEEF); lit(S_CV, 32'd0);
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        lit(S_RA, 32'hDEADBEEF); lit(S_CV, 32'd1); lit(S_CA, 32'd5);
        lit(S_CD, 32'hDEADBEEF); lit(S_CNT, 32'd1);
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        lit(S_RA, 32'hDEADBEEF); lit(S_CV, 32'd0); lit(S_CNT, 32'd1);

        // Write to x0 is dropped.
        step(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        lit(S_RA, 32'd0); lit(S_RB, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
            lit(S_RA, 32'd0); lit(S_CV, 32'd0); lit(S_CNT, 32'd1);
        end

        // Back-to-back writes to x7: younger wins.
        step(1'b1, 5'd7, 32'h11111111, 5'd7, 5'd7);
        step(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
        step(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        lit(S_RA, 32'h22222222); lit(S_RB, 32'h22222222);
        lit(S_CV, 32'd1); lit(S_CD, 32'h11111111); lit(S_CNT, 32'd2);
        step(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        lit(S_RA, 32'h22222222); lit(S_RB, 32'h22222222);
        lit(S_CV, 32'd1); lit(S_CD, 32'h22222222); lit(S_CNT, 32'd3);
        step(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        lit(S_RA, 32'h22222222); lit(S_RB, 32'h22222222);
        lit(S_CV, 32'd0); lit(S_CNT, 32'd3);

        // Reset asserted mid-cycle N+1 discards the pending x3 write.
        step(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd7);
        step(1'b0, 5'd0, 32'd0, 5'd3, 5'd7);
        #2 rst_i = 1'b1;
        lit(S_RA, 32'd0); lit(S_RB, 32'd0); lit(S_CV, 32'd0); lit(S_CNT, 32'd0);
        step(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        lit(S_RA, 32'd0); lit(S_CV, 32'd0);
        step(1'b0, 5'd0, 32'd0, 5'd3, 5'd7);
        rst_i = 1'b0;
        lit(S_RA, 32'd0); lit(S_RB, 32'd0); lit(S_CV, 32'd0); lit(S_CNT, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 5'd0, 32'd0, 5'd3, 5'd5);
            lit(S_RA, 32'd0); lit(S_RB, 32'd0); lit(S_CV, 32'd0); lit(S_CNT, 32'd0);
        end

        // Counter wrap via backdoor deposit.
        step(1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
        dut.commit_cnt_reg = 32'hFFFFFFFF;
        cnt_base = 32'hFFFFFFFF - ncommit;
        lit(S_CNT, 32'hFFFFFFFF);
        step(1'b1, 5'd1, 32'hCAFEF00D, 5'd0, 5'd1);
        lit(S_CNT, 32'hFFFFFFFF);
        step(1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
        lit(S_RA, 32'hCAFEF00D); lit(S_CNT, 32'hFFFFFFFF); lit(S_CV, 32'd0);
        step(1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
        lit(S_CV, 32'd1); lit(S_CA, 32'd1); lit(S_CD, 32'hCAFEF00D); lit(S_CNT, 32'd0);
        step(1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
        lit(S_RA, 32'hCAFEF00D); lit(S_CV, 32'd0); lit(S_CNT, 32'd0);

        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk_i);
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the execute-stage register-write interface.
- Captures the EX result (write enable, destination address, data) into a write-back pipeline register, then commits it into a 32 x 32-bit integer register file one cycle later.
- Provides two combinational read ports to decode, with forwarding from the pending write-back entry.
- x0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; x0 is read-only zero.
- ADDR_W, 5, register address width; equals log2(NUM_REGS).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- reg_we_i  input  1  write enable from EX.
- wr_addr_i  input  ADDR_W  destination register from EX.
- rd_wdata_i  input  DATA_W  write data from EX.
- raddr_a_i  input  ADDR_W  read port A address.
- raddr_b_i  input  ADDR_W  read port B address.
- rdata_a_o  output  DATA_W  read port A data, combinational.
- rdata_b_o  output  DATA_W  read port B data, combinational.
- commit_valid_o  output  1  pulses high in the cycle a write commits to the array.
- commit_addr_o  output  ADDR_W  committed register address.
- commit_data_o  output  DATA_W  committed data.
- commit_cnt_o  output  32  running count of committed writes.

Behaviour:
- Reset (rst_i high, asynchronous assert):
  - all array entries = 0.
  - wb_valid_q = 0, wb_addr_q = 0, wb_data_q = 0.
  - commit_valid_o = 0, commit_addr_o = 0, commit_data_o = 0, commit_cnt_o = 0.
  - rdata_*_o = 0 while in reset.
  - Reset mid-operation discards any pending write-back entry; that write is lost.
- Stage 1, capture, every rising edge:
  - wb_valid_q <= reg_we_i && (wr_addr_i != 0).
  - wb_addr_q <= wr_addr_i; wb_data_q <= rd_wdata_i.
  - Writes addressed to x0 are dropped here: no commit, no count.
- Stage 2, commit, every rising edge with wb_valid_q = 1:
  - array[wb_addr_q] <= wb_data_q.
  - commit_valid_o/addr/data registered from the wb_* values; commit_valid_o is high for exactly one cycle per write.
  - commit_cnt_o increments by 1 and wraps from 0xFFFFFFFF to 0.
- Latency:
  - Write presented in cycle N is captured at the end of N and committed at the end of N+1.
  - commit_valid_o is high in cycle N+2.
- Read priority, per port, combinational:
  1. raddr == 0 -> 0.
  2. (bypass macro only) reg_we_i && wr_addr_i == raddr -> rd_wdata_i.
  3. wb_valid_q && wb_addr_q == raddr -> wb_data_q.
  4. otherwise array[raddr].
- Back-to-back writes to the same register: the younger write wins in both forwarding and the array. The older write commits first and is overwritten one cycle later.
- Both read ports may address the same register; each resolves independently and returns identical data.
- No stall input. EX drives one write per cycle at most, and every write is accepted unconditionally.

Optional Feature:
- Macro: WB_EX_BYPASS_EN.
- Defined:
  - Read ports also forward rd_wdata_i combinationally when reg_we_i = 1 and wr_addr_i matches a nonzero read address, with priority over the wb entry.
  - A write is visible on the read ports in the same cycle N.
- Undefined:
  - No EX-path forwarding; the write is first visible in cycle N+1 via the wb entry.
  - No combinational path from the EX inputs to rdata_*_o.
- Commit timing and counter behaviour are identical in both builds.

Test Plan:
- Reset release, no writes; read all 32 addresses on both ports -> every read returns 0x00000000; commit_cnt_o = 0; commit_valid_o = 0.
- Cycle N: we = 1, addr = 5, data = 0xDEADBEEF; raddr_a = 5 in cycles N, N+1, N+2, N+3:
  - cycle N: 0 without the macro, 0xDEADBEEF with it.
  - cycles N+1 to N+3: 0xDEADBEEF.
  - commit_valid_o high only in N+2 with addr 5 and data 0xDEADBEEF.
  - commit_cnt_o = 1.
- Write to x0 with data 0x12345678 -> rdata for x0 stays 0; commit_valid_o is never asserted; commit_cnt_o unchanged.
- Back-to-back writes: x7 = 0x11111111 in cycle N, x7 = 0x22222222 in cycle N+1; read x7 on both ports:
  - from cycle N+2 onward, both ports return 0x22222222.
  - array holds 0x22222222 after N+2.
  - commit_cnt_o increases by 2.
- Reset mid-operation: write x3 = 0xAAAA5555 in cycle N; assert rst_i asynchronously mid-cycle N+1 -> x3 reads 0; commit_valid_o stays low; commit_cnt_o = 0 after reset release.
- Counter wrap: force commit_cnt_o to 0xFFFFFFFF via a backdoor deposit, then perform one write to x1 -> commit_cnt_o = 0x00000000 in the cycle after the commit.
